mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port 16 KB word RAM between three requesters: core instruction fetch (I), core load/store (D) and a boot/program loader (L).
- Replaces the dual-port RAM so the core can target single-port block RAM.
- Arbitrates requests, performs read-modify-write for sub-word stores, and returns shifted load data, keeping the core's existing byte-lane semantics.

Parameters:
- ADDR_W, 14, byte address width (RAM = 2^ADDR_W bytes).
- DATA_W, 32, data width; fixed at 32, not intended to change.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-high (asserted = 1 resets the block).
- i_req  in  1  fetch request, held until i_gnt.
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid this cycle.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request, held until d_gnt.
- d_addr  in  ADDR_W  data byte address.
- d_wsize  in  2  00 load, 01 byte store, 10 half store, 11 word store.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data request accepted.
- d_err  out  1  misaligned request; pulses with d_gnt.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  32  load word shifted right by 8*d_addr[1:0], zero-filled.
- l_req  in  1  loader word write request.
- l_addr  in  ADDR_W  loader byte address; bits [1:0] ignored.
- l_wdata  in  32  loader word.
- l_gnt  out  1  loader write accepted.
- busy  out  1  RMW in progress; no grants this cycle.

Behaviour:
- Reset (resetn=1 at clk edge):
  - all gnt, rvalid and err outputs are 0; i_rdata and d_rdata are 0.
  - state = IDLE; round-robin pointer = I.
  - RAM contents are not cleared.
  - Reset during RMW drops the pending write.
- FSM states: IDLE and RMW.
- IDLE winner selection, combinational (Mealy gnt in the same cycle the request is seen):
  - l_req wins unconditionally.
  - Otherwise a sole requester wins.
  - If both i_req and d_req are set, the pointer decides.
  - After an I or D grant the pointer moves to the other port; an L grant leaves it unchanged.
  - A continuous l_req starves I and D by design.
- Reads (I, or D with d_wsize=00):
  - RAM read issued in the grant cycle; rvalid pulses exactly 1 cycle later.
  - i_rdata is the word at i_addr[ADDR_W-1:2].
  - d_rdata is the word >> 8*d_addr[1:0]; no word-boundary crossing.
  - rdata registers hold their value until the next rvalid.
- Word store (11):
  - requires d_addr[1:0]=00; written at the grant edge; no rvalid.
- Sub-word store (01 byte any offset; 10 half requires d_addr[0]=0):
  - Grant cycle issues the RAM read; FSM goes to RMW.
  - RMW cycle: merge d_wdata[7:0] or [15:0] into the lane selected by d_addr[1:0], write the word, busy=1, no grants, return to IDLE.
  - Store data and address are captured at grant, so the requester may change inputs after d_gnt.
- Misaligned request (half with addr[0]=1; word store with addr[1:0]≠00):
  - d_gnt=1 and d_err=1 in the same cycle.
  - No RAM write, no rvalid; the pointer still advances.
  - Loads are never misaligned.
- Ordering and hazards:
  - A read granted in the cycle after a write to the same word returns the new data.
  - A request arriving during RMW waits; it is granted in the following IDLE cycle.
- Maximum throughput: 1 grant per cycle, except 2 cycles for a sub-word store.

Decomposition:
- Package mem_arb_pkg holds:
  - size constants SZ_LOAD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b11;
  - state enum {ST_IDLE, ST_RMW};
  - requester id enum {REQ_I, REQ_D, REQ_L}.
- One sub-module, spram_word: 2^(ADDR_W-2) x 32 words, 1-cycle registered read, synchronous word write, single port.
- Arbitration, merge and shift logic stay in mem_arbiter.

Test Plan:
- Reset: resetn=1 for 2 cycles with i_req=d_req=1 -> no gnt. Release -> i_gnt first, then d_gnt on the next cycle (alternation).
- Loader then read: l_req write 0xDEADBEEF @0x0010 -> l_gnt. Next cycle i_req @0x0012 -> i_gnt; next cycle i_rvalid=1, i_rdata=0xDEADBEEF.
- Shifted load: word 0xDEADBEEF @0x0010; d load @0x0013 -> d_rdata=0x000000DE, one cycle after d_gnt.
- Byte RMW: d_wsize=01 @0x0011, d_wdata=0x55 -> busy=1 next cycle and i_req held (no i_gnt that cycle). Later word read of 0x0010 = 0xDEAD55EF.
- Misaligned: half store @0x0013 -> d_gnt=1, d_err=1, memory unchanged; word store @0x0012 -> d_err=1.
- Contention: l_req, i_req and d_req all held -> l_gnt every cycle. Drop l_req -> I and D alternate. Reset asserted in the RMW cycle -> target word unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter.
//   SZ_*      : encodings of the data-port d_wsize field
//   state_e   : arbiter FSM states
//   req_e     : requester identifiers (round-robin pointer values)
//   merge_word: inserts a byte or half-word into a 32-bit word at a byte offset
package mem_arb_pkg;

  localparam logic [1:0] SZ_LOAD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic {ST_IDLE, ST_RMW} state_e;

  typedef enum logic [1:0] {REQ_I, REQ_D, REQ_L} req_e;

  // Only SZ_BYTE and SZ_HALF reach this; anything else is treated as a half.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] data;
    if (size == SZ_BYTE) begin
      mask = 32'h0000_00ff << {off, 3'b000};
      data = {24'b0, wdata[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {off, 3'b000};
      data = {16'b0, wdata[15:0]} << {off, 3'b000};
    end
    return (old_word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/spram_word.sv
// Single-port word RAM, 2^AW x 32, with a registered read port.
//   clk   : clock
//   en    : access enable
//   we    : write enable (when en); otherwise a read is performed
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read; holds across writes/idle
module spram_word #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word RAM between instruction fetch (I),
// core load/store (D) and a program loader (L).
//   clk, resetn               : clock, synchronous active-high reset
//   i_req/i_addr/i_gnt        : fetch request/address/accept
//   i_rvalid/i_rdata          : fetch data, one cycle after i_gnt
//   d_req/d_addr/d_wsize      : data request, byte address, size (00 load)
//   d_wdata                   : right-aligned store data
//   d_gnt/d_err               : accept; d_err flags a misaligned store
//   d_rvalid/d_rdata          : load data shifted right by the byte offset
//   l_req/l_addr/l_wdata/l_gnt: loader word write
//   busy                      : sub-word store read-modify-write in progress
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_wsize,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_err,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              busy
);

  localparam int WA_W = ADDR_W - 2;

  state_e            state_q;
  req_e              ptr_q;
  logic [WA_W-1:0]   rmw_addr_q;
  logic [1:0]        rmw_size_q;
  logic [1:0]        rmw_off_q;
  logic [DATA_W-1:0] rmw_wdata_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic [1:0]        d_shift_q;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  logic              win_i, win_d, win_l;
  logic              d_misalign, d_sub;
  logic              ram_en, ram_we;
  logic [WA_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] d_shifted;

  // Word-aligned ports ignore the low address bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], l_addr[1:0]};

  assign d_misalign = ((d_wsize == SZ_HALF) && d_addr[0]) ||
                      ((d_wsize == SZ_WORD) && (d_addr[1:0] != 2'b00));
  assign d_sub      = (d_wsize == SZ_BYTE) || ((d_wsize == SZ_HALF) && !d_addr[0]);

  // Winner selection; no grants while in reset or during the RMW write cycle.
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    win_l = 1'b0;
    if (!resetn && (state_q == ST_IDLE)) begin
      if (l_req) begin
        win_l = 1'b1;
      end else if (i_req && d_req) begin
        if (ptr_q == REQ_I) win_i = 1'b1;
        else                win_d = 1'b1;
      end else if (i_req) begin
        win_i = 1'b1;
      end else if (d_req) begin
        win_d = 1'b1;
      end
    end
  end

  // RAM port steering. In the RMW cycle ram_rdata still holds the word read
  // in the grant cycle, since the RAM output only updates on reads.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = i_addr[ADDR_W-1:2];
    ram_wdata = l_wdata;
    if (resetn) begin
      ram_en = 1'b0;
    end else if (state_q == ST_RMW) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = rmw_addr_q;
      ram_wdata = merge_word(ram_rdata, rmw_wdata_q, rmw_size_q, rmw_off_q);
    end else if (win_l) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = l_addr[ADDR_W-1:2];
      ram_wdata = l_wdata;
    end else if (win_i) begin
      ram_en   = 1'b1;
      ram_addr = i_addr[ADDR_W-1:2];
    end else if (win_d && !d_misalign) begin
      ram_en    = 1'b1;
      ram_we    = (d_wsize == SZ_WORD);
      ram_addr  = d_addr[ADDR_W-1:2];
      ram_wdata = d_wdata;
    end
  end

  spram_word #(
    .AW (WA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign d_shifted = ram_rdata >> {d_shift_q, 3'b000};

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= REQ_I;
      rmw_addr_q  <= '0;
      rmw_size_q  <= SZ_LOAD;
      rmw_off_q   <= 2'b00;
      rmw_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_shift_q   <= 2'b00;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
    end else begin
      i_rvalid_q <= win_i;
      d_rvalid_q <= win_d && (d_wsize == SZ_LOAD);
      if (i_rvalid_q) i_hold_q <= ram_rdata;
      if (d_rvalid_q) d_hold_q <= d_shifted;
      if (win_i)      ptr_q <= REQ_D;
      else if (win_d) ptr_q <= REQ_I;
      if (win_d)      d_shift_q <= d_addr[1:0];
      case (state_q)
        ST_IDLE: begin
          if (win_d && d_sub) begin
            state_q     <= ST_RMW;
            rmw_addr_q  <= d_addr[ADDR_W-1:2];
            rmw_size_q  <= d_wsize;
            rmw_off_q   <= d_addr[1:0];
            rmw_wdata_q <= d_wdata;
          end
        end
        ST_RMW:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data is live in the rvalid cycle and held afterwards.
  assign i_gnt    = win_i;
  assign d_gnt    = win_d;
  assign l_gnt    = win_l;
  assign d_err    = win_d && d_misalign;
  assign busy     = (state_q == ST_RMW);
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rvalid_q ? ram_rdata : i_hold_q;
  assign d_rdata  = d_rvalid_q ? d_shifted : d_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req, d_req, l_req;
  logic [13:0] i_addr, d_addr, l_addr;
  logic [1:0]  d_wsize;
  logic [31:0] d_wdata, l_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_err, d_rvalid, l_gnt, busy;
  logic [31:0] i_rdata, d_rdata;

  mem_arbiter #(
    .ADDR_W (14),
    .DATA_W (32)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_wsize  (d_wsize),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_err    (d_err),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .l_req    (l_req),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .busy     (busy)
  );

  typedef struct {
    int          cyc;
    bit          known;
    logic [31:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] mem_m [4096];
  bit          known_m [4096];
  int          cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  string       phase = "init";

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare handshake outputs against expectations at the
  // falling edge, update the memory model / scoreboard for expected grants.
  task automatic cyc(input bit ei, input bit ed, input bit el, input bit ee, input bit eb);
    int          w;
    int          off;
    logic [31:0] t;
    @(negedge clk);
    check({phase, ":i_gnt"}, 32'(i_gnt), 32'(ei));
    check({phase, ":d_gnt"}, 32'(d_gnt), 32'(ed));
    check({phase, ":l_gnt"}, 32'(l_gnt), 32'(el));
    check({phase, ":d_err"}, 32'(d_err), 32'(ee));
    check({phase, ":busy"},  32'(busy),  32'(eb));
    if (ei) begin
      w = int'(i_addr[13:2]);
      iq.push_back('{cnt, known_m[w], mem_m[w]});
    end
    if (el) begin
      w = int'(l_addr[13:2]);
      mem_m[w]   = l_wdata;
      known_m[w] = 1'b1;
    end
    if (ed && !ee) begin
      w   = int'(d_addr[13:2]);
      off = int'(d_addr[1:0]);
      t   = mem_m[w];
      case (d_wsize)
        2'b00: dq.push_back('{cnt, known_m[w], t >> (8 * off)});
        2'b01: t[8*off +: 8] = d_wdata[7:0];
        2'b10: t[8*off +: 16] = d_wdata[15:0];
        default: begin
          t          = d_wdata;
          known_m[w] = 1'b1;
        end
      endcase
      mem_m[w] = t;
    end
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor: each rvalid must match the oldest outstanding read,
  // exactly one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (iq.size() > 0 && iq[0].cyc + 1 < cnt) begin
      check("i_rvalid_missing", 32'(0), 32'(1));
      void'(iq.pop_front());
    end
    if (dq.size() > 0 && dq[0].cyc + 1 < cnt) begin
      check("d_rvalid_missing", 32'(0), 32'(1));
      void'(dq.pop_front());
    end
    if (i_rvalid) begin
      if (iq.size() == 0) begin
        check("i_rvalid_unexpected", 32'(1), 32'(0));
      end else begin
        e = iq.pop_front();
        check("i_latency", 32'(cnt - e.cyc), 32'(1));
        if (e.known) check("i_rdata", i_rdata, e.data);
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) begin
        check("d_rvalid_unexpected", 32'(1), 32'(0));
      end else begin
        e = dq.pop_front();
        check("d_latency", 32'(cnt - e.cyc), 32'(1));
        if (e.known) check("d_rdata", d_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    resetn  = 1'b1;
    i_req   = 1'b1;
    i_addr  = 14'h0020;
    d_req   = 1'b1;
    d_addr  = 14'h0024;
    d_wsize = 2'b00;
    d_wdata = '0;
    l_req   = 1'b0;
    l_addr  = '0;
    l_wdata = '0;

    // Reset held with I and D requesting
    phase = "reset";
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0);
    check("reset:i_rvalid", 32'(i_rvalid), 32'(0));
    check("reset:d_rvalid", 32'(d_rvalid), 32'(0));
    check("reset:i_rdata", i_rdata, 32'h0);
    check("reset:d_rdata", d_rdata, 32'h0);
    resetn = 1'b0;
    phase  = "alternate";
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    i_req = 1'b0;
    d_req = 1'b0;

    // Loader write then fetch
    phase   = "loader";
    l_req   = 1'b1;
    l_addr  = 14'h0010;
    l_wdata = 32'hdead_beef;
    cyc(0, 0, 1, 0, 0);
    l_req  = 1'b0;
    i_req  = 1'b1;
    i_addr = 14'h0012;
    cyc(1, 0, 0, 0, 0);
    i_req = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("loader:i_rdata_hold", i_rdata, 32'hdead_beef);

    // Shifted load
    phase   = "shift";
    d_req   = 1'b1;
    d_addr  = 14'h0013;
    d_wsize = 2'b00;
    cyc(0, 1, 0, 0, 0);
    d_req = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("shift:d_rdata_hold", d_rdata, 32'h0000_00de);

    // Byte and half RMW; inputs scrambled after grant
    phase   = "rmw";
    d_req   = 1'b1;
    d_wsize = 2'b01;
    d_addr  = 14'h0011;
    d_wdata = 32'h0000_0055;
    cyc(0, 1, 0, 0, 0);
    d_req   = 1'b0;
    d_wdata = 32'hffff_ffff;
    d_addr  = 14'h3fff;
    i_req   = 1'b1;
    i_addr  = 14'h0010;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_wsize = 2'b10;
    d_addr  = 14'h0012;
    d_wdata = 32'habcd_1234;
    cyc(0, 1, 0, 0, 0);
    d_req = 1'b0;
    cyc(0, 0, 0, 0, 1);
    d_req   = 1'b1;
    d_wsize = 2'b00;
    d_addr  = 14'h0010;
    cyc(0, 1, 0, 0, 0);
    d_addr = 14'h0012;
    cyc(0, 1, 0, 0, 0);
    d_req = 1'b0;

    // Misaligned stores, then aligned word store with read-after-write
    phase   = "misalign";
    d_req   = 1'b1;
    d_wsize = 2'b10;
    d_addr  = 14'h0013;
    d_wdata = 32'h0000_ffff;
    cyc(0, 1, 0, 1, 0);
    d_wsize = 2'b11;
    d_addr  = 14'h0012;
    d_wdata = 32'h0bad_0bad;
    cyc(0, 1, 0, 1, 0);
    d_req  = 1'b0;
    i_req  = 1'b1;
    i_addr = 14'h0010;
    cyc(1, 0, 0, 0, 0);
    i_req   = 1'b0;
    phase   = "word";
    d_req   = 1'b1;
    d_wsize = 2'b11;
    d_addr  = 14'h0020;
    d_wdata = 32'hcafe_f00d;
    cyc(0, 1, 0, 0, 0);
    d_wsize = 2'b00;
    cyc(0, 1, 0, 0, 0);
    d_req = 1'b0;

    // Contention: loader starves I and D, then I/D alternate
    phase   = "contend";
    l_req   = 1'b1;
    i_req   = 1'b1;
    i_addr  = 14'h0010;
    d_req   = 1'b1;
    d_wsize = 2'b00;
    d_addr  = 14'h0021;
    for (int k = 0; k < 3; k++) begin
      l_addr  = 14'(14'h0030 + 4 * k);
      l_wdata = 32'h1111_1111 * (k + 1);
      cyc(0, 0, 1, 0, 0);
    end
    l_req = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    d_req  = 1'b0;
    i_addr = 14'h0034;
    cyc(1, 0, 0, 0, 0);
    i_req = 1'b0;

    // Reset during RMW drops the write
    phase   = "rmw_reset";
    saved   = mem_m[8];
    d_req   = 1'b1;
    d_wsize = 2'b01;
    d_addr  = 14'h0020;
    d_wdata = 32'h0000_0077;
    cyc(0, 1, 0, 0, 0);
    mem_m[8] = saved;
    d_req    = 1'b0;
    resetn   = 1'b1;
    cyc(0, 0, 0, 0, 1);
    resetn  = 1'b0;
    d_req   = 1'b1;
    d_wsize = 2'b00;
    cyc(0, 1, 0, 0, 0);
    d_req = 1'b0;

    phase = "drain";
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("drain:iq_empty", 32'(iq.size()), 32'(0));
    check("drain:dq_empty", 32'(dq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
